// File: rtl/tcp_tx_arb_pkg.sv
// Shared types and helpers for the two-source TCP transmit arbiter.
// Holds the FSM encoding, the ESTABLISHED default, keep popcount and the round-robin pick.
package tcp_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  localparam logic [3:0] TCP_STATE_ESTABLISHED_DEFAULT = 4'd4;

  function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

  // With both sources requesting, the one that did not own the last segment wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

endpackage

// File: rtl/tcp_seg_byte_counter.sv
// Accumulates payload bytes of the segment in flight and flags the beat that closes it:
// either the byte total reaches the segment length or the beat is a short final beat.
module tcp_seg_byte_counter
  import tcp_tx_arb_pkg::*;
#(
  parameter int TCP_DATA_LENGTH = 1456,
  localparam int CW = $clog2(TCP_DATA_LENGTH + 8)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          beat_i,
  input  logic [7:0]    tkeep_i,
  output logic          seg_end_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] SEG_LEN = CW'(TCP_DATA_LENGTH);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] sum;

  assign sum       = count_q + CW'(keep_popcount(tkeep_i));
  assign seg_end_o = beat_i && ((sum >= SEG_LEN) || (tkeep_i != 8'hFF));
  assign count_o   = count_q;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (beat_i) count_d = seg_end_o ? '0 : sum;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Segment-aligned round-robin arbiter sharing the TCP core's transmit user stream between
// two AXI-Stream sources; ownership changes only on segment boundaries while ESTABLISHED.
module tcp_tx_arbiter
  import tcp_tx_arb_pkg::*;
#(
  parameter int         TCP_DATA_LENGTH       = 1456,
  parameter logic [3:0] TCP_STATE_ESTABLISHED = TCP_STATE_ESTABLISHED_DEFAULT
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  input  logic [3:0]  tcp_state_in,
  input  logic        s0_axis_tvalid,
  output logic        s0_axis_tready,
  input  logic [63:0] s0_axis_tdata,
  input  logic [7:0]  s0_axis_tkeep,
  input  logic        s1_axis_tvalid,
  output logic        s1_axis_tready,
  input  logic [63:0] s1_axis_tdata,
  input  logic [7:0]  s1_axis_tkeep,
  output logic        tx_user_tvalid,
  input  logic        tx_user_tready,
  output logic [63:0] tx_user_tdata,
  output logic [7:0]  tx_user_tkeep,
  output logic        grant,
  output logic        busy,
  output logic [31:0] seg_count0,
  output logic [31:0] seg_count1
);

  localparam int            CW      = $clog2(TCP_DATA_LENGTH + 8);
  localparam logic [CW-1:0] SEG_LEN = CW'(TCP_DATA_LENGTH);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [31:0]   seg_count0_q, seg_count0_d;
  logic [31:0]   seg_count1_q, seg_count1_d;
  logic          req0, req1, beat, seg_end;
  logic [CW-1:0] seg_bytes;

  // Outputs are zero outside SEND, which also makes reset force them low immediately.
  assign busy           = (state_q == ST_SEND);
  assign grant          = grant_q;
  assign tx_user_tvalid = busy & (grant_q ? s1_axis_tvalid : s0_axis_tvalid);
  assign tx_user_tdata  = busy ? (grant_q ? s1_axis_tdata : s0_axis_tdata) : '0;
  assign tx_user_tkeep  = busy ? (grant_q ? s1_axis_tkeep : s0_axis_tkeep) : '0;
  assign s0_axis_tready = busy & ~grant_q & tx_user_tready;
  assign s1_axis_tready = busy &  grant_q & tx_user_tready;
  assign seg_count0     = seg_count0_q;
  assign seg_count1     = seg_count1_q;

  assign beat = tx_user_tvalid & tx_user_tready;
  assign req0 = (tcp_state_in == TCP_STATE_ESTABLISHED) & s0_axis_tvalid;
  assign req1 = (tcp_state_in == TCP_STATE_ESTABLISHED) & s1_axis_tvalid;

  tcp_seg_byte_counter #(.TCP_DATA_LENGTH(TCP_DATA_LENGTH)) u_byte_counter (
    .clk       (s_aclk),
    .rst_n     (s_aresetn),
    .beat_i    (beat),
    .tkeep_i   (tx_user_tkeep),
    .seg_end_o (seg_end),
    .count_o   (seg_bytes)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    seg_count0_d = seg_count0_q;
    seg_count1_d = seg_count1_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_SEND;
          grant_d = rr_pick(req0, req1, last_grant_q);
        end
      end
      ST_SEND: begin
        // Re-arbitrate on the closing beat so back-to-back segments have no bubble.
        if (seg_end) begin
          last_grant_d = grant_q;
          if (grant_q) seg_count1_d = seg_count1_q + 32'd1;
          else         seg_count0_d = seg_count0_q + 32'd1;
          if (req0 || req1) grant_d = rr_pick(req0, req1, grant_q);
          else              state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      seg_count0_q <= '0;
      seg_count1_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      seg_count0_q <= seg_count0_d;
      seg_count1_q <= seg_count1_d;
    end
  end

  // A segment always closes on the beat that reaches its length, so the running count stays below it.
  assert property (@(posedge s_aclk) disable iff (!s_aresetn) seg_bytes < SEG_LEN);

endmodule

// File: doc/tcp_tx_arbiter.md
# tcp_tx_arbiter

Segment-aligned round-robin arbiter sharing the TCP core's single transmit user stream (`tx_user_*`, 64-bit data with 8-bit keep) between two user AXI-Stream sources. Typical sources are the traffic generator and a second payload source. The block sits between the sources and `axi_10g_ethernet_0_user_data` in the `coreclk_out` domain. It switches sources only on TCP segment boundaries of `TCP_DATA_LENGTH` bytes, and grants only while the TCP connection is ESTABLISHED.

## Interface
Parameters:
- `TCP_DATA_LENGTH`, default 1456: segment payload size in bytes. Must be ≥ 8.
- `TCP_STATE_ESTABLISHED`, default 4'd4: encoding of `tcp_state_out` that means ESTABLISHED.

Ports:
- `s_aclk` (in, 1): single clock (`coreclk_out`, 156.25 MHz).
- `s_aresetn` (in, 1): **asynchronous, active-low reset.**
- `tcp_state_in` (in, 4): TCP core state (`tcp_state_out`).
- `s0_axis_tvalid`, `s0_axis_tready`, `s0_axis_tdata`, `s0_axis_tkeep` (in/out/in/in; 1/1/64/8): source 0.
- `s1_axis_tvalid`, `s1_axis_tready`, `s1_axis_tdata`, `s1_axis_tkeep` (in/out/in/in; 1/1/64/8): source 1.
- `tx_user_tvalid`, `tx_user_tready`, `tx_user_tdata`, `tx_user_tkeep` (out/in/out/out; 1/1/64/8): output to the TCP core.
- `grant` (out, 1): index of the current owner. Meaningful only when `busy` = 1.
- `busy` (out, 1): a segment is in progress (state SEND).
- `seg_count0`, `seg_count1` (out, 32 each): completed segments per source. Wrap at 2^32.

## Operation
- States: IDLE and SEND.
- **IDLE:**
  - `s0_axis_tready`, `s1_axis_tready` and `tx_user_tvalid` are all 0.
  - If `tcp_state_in` == `TCP_STATE_ESTABLISHED` and any `sN_axis_tvalid` = 1, pick a source round-robin and go to SEND.
  - Round-robin: prefer the source that is not `last_grant`. If only one source requests, that source wins.
- **SEND:**
  - Combinational pass-through of the granted source: `tx_user_tvalid` = `sG_tvalid`, `tx_user_tdata/tkeep` = `sG_tdata/tkeep`, `sG_tready` = `tx_user_tready`.
  - The non-granted source's `tready` is 0.
- **Byte counter:**
  - Width is `$clog2(TCP_DATA_LENGTH+8)`.
  - On each transferred beat (valid & ready), add popcount(`tkeep`).
  - A `tkeep` of 0 adds 0 bytes and is forwarded.
- **Segment end:** a transferred beat where either (counter + popcount) ≥ `TCP_DATA_LENGTH`, or `tkeep` ≠ 8'hFF (short final beat). On segment end:
  - clear the counter;
  - increment `seg_count[G]`;
  - set `last_grant` ← G;
  - re-arbitrate in the same cycle on the current tvalids and the ESTABLISHED condition. If a winner exists, stay in SEND with the new grant (no bubble); otherwise go to IDLE.
- **Leaving ESTABLISHED mid-segment:** the current segment completes. No new grant is issued after it.
- Non-contiguous `tkeep` is forwarded unchanged and counted by popcount.
- **Reset (async, any time):**
  - state = IDLE; counter, `last_grant` (=1, so source 0 wins the first tie), `grant` and both `seg_count`s = 0;
  - all `tready` = 0, `tx_user_tvalid` = 0, `busy` = 0;
  - tdata/tkeep outputs = 0.
  - Reset mid-segment abandons that segment. It is not counted.

## Timing
- Grant latency: a request seen in IDLE gives SEND on the next edge. The first beat is forwarded in that next cycle, so there is one bubble cycle per idle-to-busy transition.
- Data path latency: 0 cycles (combinational mux). `tready` depends combinationally on `tx_user_tready`.
- Back-to-back segments, whether same or other source: no idle cycle between them.
- Full 1456-byte segment = 182 beats of 8'hFF.
- The AXI rule holds: the arbiter never deasserts `tx_user_tvalid` mid-beat on its own. A source tvalid drop mid-segment stalls the output; the grant is held.
- `grant` and `busy` are registered and change only on a segment-end or IDLE-exit edge.

## Structure
- Package `tcp_tx_arb_pkg`: state enum (IDLE, SEND), the `TCP_STATE_ESTABLISHED` default, and a keep-popcount function.
- Sub-module `tcp_seg_byte_counter`: accumulates the byte count per beat and flags segment end. Inputs: beat, tkeep. Outputs: `seg_end`, `count`.
- The arbiter FSM, mux and statistics stay in the top.

## Test plan
- **Single source:** state 4, s0 sends 182 beats of FF with ready held 1 → `busy` rises 1 cycle after the first valid; all 182 beats pass unchanged; `seg_count0` = 1; back to IDLE.
- **Both sources continuously valid:** 4 segments → grant order 0,1,0,1; no gap cycle between segments; `seg_count0` = `seg_count1` = 2.
- **Short segment:** s1 sends 10 beats of FF then keep 8'h0F (84 bytes) → segment ends on that beat; grant passes to s0 if s0 is valid.
- **State leaves 4:** `tcp_state_in` changes 4 → 5 at beat 50 of an s0 segment → remaining 132 beats complete; then IDLE; s1 valid gets no ready.
- **Backpressure:** `tx_user_tready` toggles randomly → data order is preserved; the byte count still ends the segment at exactly 1456 bytes; the non-granted tready stays 0 throughout.
- **Async reset:** `s_aresetn` asserted at beat 100 → all outputs go to 0 immediately; after release, the next segment counts from 0 and source 0 wins the tie.
